// File: rtl/display_timing_pkg.sv
// display_timing_pkg: shared timing descriptor, standard mode presets and decode helpers
package display_timing_pkg;
  typedef struct packed {
    int active;
    int fp;
    int sync;
    int bp;
  } timing_t;
  localparam timing_t VGA_640X480_H  = '{active: 640, fp: 16, sync: 96,  bp: 48};
  localparam timing_t VGA_640X480_V  = '{active: 480, fp: 10, sync: 2,   bp: 33};
  localparam timing_t SVGA_800X600_H = '{active: 800, fp: 40, sync: 128, bp: 88};
  localparam timing_t SVGA_800X600_V = '{active: 600, fp: 1,  sync: 4,   bp: 23};
  function automatic int total(timing_t t);
    return t.active + t.fp + t.sync + t.bp;
  endfunction
  function automatic bit in_sync(int pos, timing_t t);
    return pos >= t.active + t.fp && pos < t.active + t.fp + t.sync;
  endfunction
  function automatic bit cfg_ok(timing_t t, int cw);
    return t.active >= 1 && t.fp >= 1 && t.sync >= 1 && t.bp >= 1 &&
           longint'(total(t)) <= (longint'(1) << cw);
  endfunction
endpackage

// File: rtl/timing_axis_counter.sv
// timing_axis_counter: one raster axis counter with wrap pulse and active/sync decode
module timing_axis_counter
  import display_timing_pkg::*;
#(
  parameter timing_t T  = VGA_640X480_H,
  parameter int      CW = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          adv,
  output logic [CW-1:0] count,
  output logic          wrap,
  output logic          active,
  output logic          sync
);
  localparam logic [CW-1:0] LAST = CW'(total(T) - 1);
  always_ff @(posedge clk)
    if (reset) count <= '0;
    else if (adv) count <= wrap ? '0 : count + CW'(1);
  always_comb begin
    wrap   = adv && count == LAST;
    active = int'(count) < T.active;
    sync   = in_sync(int'(count), T);
  end
endmodule

// File: rtl/display_timing_gen.sv
// display_timing_gen: parametrised raster timing generator; DISPLAY_TIMING_FRAME_COUNT_EN adds frame_count
module display_timing_gen
  import display_timing_pkg::*;
#(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter bit H_SYNC_POL = 1'b0,
  parameter bit V_SYNC_POL = 1'b0,
  parameter int CW         = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pixel_en,
  output logic [CW-1:0] s_x,
  output logic [CW-1:0] s_y,
  output logic          h_sync,
  output logic          v_sync,
  output logic          data_enable,
  output logic          line_start,
`ifdef DISPLAY_TIMING_FRAME_COUNT_EN
  output logic          frame_start,
  output logic [15:0]   frame_count
`else
  output logic          frame_start
`endif
);
  localparam timing_t HT = '{active: H_ACTIVE, fp: H_FP, sync: H_SYNC, bp: H_BP};
  localparam timing_t VT = '{active: V_ACTIVE, fp: V_FP, sync: V_SYNC, bp: V_BP};
  if (!cfg_ok(HT, CW) || !cfg_ok(VT, CW)) begin : g_bad_cfg
    $error("display_timing_gen: interval < 1 or CW too narrow for H/V totals");
  end
  logic [CW-1:0] cnt_x, cnt_y;
  logic h_wrap, v_wrap, h_act, v_act, h_in_sync, v_in_sync;
  timing_axis_counter #(.T(HT), .CW(CW)) u_h (
    .clk(clk), .reset(reset), .adv(pixel_en),
    .count(cnt_x), .wrap(h_wrap), .active(h_act), .sync(h_in_sync)
  );
  timing_axis_counter #(.T(VT), .CW(CW)) u_v (
    .clk(clk), .reset(reset), .adv(h_wrap),
    .count(cnt_y), .wrap(v_wrap), .active(v_act), .sync(v_in_sync)
  );
  // outputs are the registered decode of the counters, so they trail them by one enabled cycle
  always_ff @(posedge clk)
    if (reset) begin
      s_x         <= '0;
      s_y         <= '0;
      h_sync      <= ~H_SYNC_POL;
      v_sync      <= ~V_SYNC_POL;
      data_enable <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (pixel_en) begin
      s_x         <= cnt_x;
      s_y         <= cnt_y;
      h_sync      <= h_in_sync ? H_SYNC_POL : ~H_SYNC_POL;
      v_sync      <= v_in_sync ? V_SYNC_POL : ~V_SYNC_POL;
      data_enable <= h_act && v_act;
      line_start  <= cnt_x == '0;
      frame_start <= cnt_x == '0 && cnt_y == '0;
    end
`ifdef DISPLAY_TIMING_FRAME_COUNT_EN
  logic [15:0] fc_int;
  // fc_int bumps on the counter wrap; frame_count trails it to line up with frame_start
  always_ff @(posedge clk)
    if (reset) begin
      fc_int      <= '0;
      frame_count <= '0;
    end else if (pixel_en) begin
      frame_count <= fc_int;
      if (v_wrap) fc_int <= fc_int + 16'd1;
    end
`else
  logic unused_v_wrap;
  assign unused_v_wrap = v_wrap;
`endif
endmodule

// File: tb/tb_display_timing_gen.sv
// tb_display_timing_gen: scoreboard bench on a 14x8 raster, both sync polarities
module tb_display_timing_gen;
  localparam int CW = 4;
  logic clk = 1'b0, reset = 1'b1, pixel_en = 1'b0;
  logic [CW-1:0] s_x, s_y, p_x, p_y;
  logic h_sync, v_sync, de, ls, fs, p_hs, p_vs, p_de, p_ls, p_fs;
`ifdef DISPLAY_TIMING_FRAME_COUNT_EN
  logic [15:0] fc, p_fc;
`endif
  always #5 clk = ~clk;
  display_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .CW(CW)
  ) dut (
    .clk(clk), .reset(reset), .pixel_en(pixel_en), .s_x(s_x), .s_y(s_y),
    .h_sync(h_sync), .v_sync(v_sync), .data_enable(de), .line_start(ls),
`ifdef DISPLAY_TIMING_FRAME_COUNT_EN
    .frame_start(fs), .frame_count(fc)
`else
    .frame_start(fs)
`endif
  );
  display_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1), .CW(CW)
  ) u_pol (
    .clk(clk), .reset(reset), .pixel_en(pixel_en), .s_x(p_x), .s_y(p_y),
    .h_sync(p_hs), .v_sync(p_vs), .data_enable(p_de), .line_start(p_ls),
`ifdef DISPLAY_TIMING_FRAME_COUNT_EN
    .frame_start(p_fs), .frame_count(p_fc)
`else
    .frame_start(p_fs)
`endif
  );
  typedef struct {
    logic [CW-1:0] x, y;
    logic hs, vs, de, ls, fs, en, rst;
    logic [15:0] fc;
  } exp_t;
  exp_t q[$];
  exp_t last_e;
  int checks = 0, passed = 0;
  int mx = 0, my = 0;
  logic [15:0] fc_int = '0;
  task automatic chk(input bit ok, input string name, input string msg);
    checks++;
    if (ok) passed++;
    else $display("FAIL %s: %s", name, msg);
  endtask
  // hand-derived raster: hsync at x 10..12, vsync at y 5..6, active x<8 and y<4, totals 14 x 8
  task automatic step(input logic r, input logic en);
    exp_t e;
    @(negedge clk);
    reset = r;
    pixel_en = en;
    if (r) begin
      mx = 0;
      my = 0;
      fc_int = '0;
      e = '{x: '0, y: '0, hs: 1'b1, vs: 1'b1, de: 1'b0, ls: 1'b0, fs: 1'b0, en: 1'b0, rst: 1'b1, fc: '0};
    end else if (en) begin
      e.x = CW'(mx);
      e.y = CW'(my);
      e.hs = !(mx >= 10 && mx <= 12);
      e.vs = !(my >= 5 && my <= 6);
      e.de = mx < 8 && my < 4;
      e.ls = mx == 0;
      e.fs = mx == 0 && my == 0;
      e.en = 1'b1;
      e.rst = 1'b0;
      e.fc = fc_int;
      if (mx == 13 && my == 7) fc_int = fc_int + 16'd1;
      if (mx == 13) begin
        mx = 0;
        my = (my == 7) ? 0 : my + 1;
      end else mx++;
    end else begin
      e = last_e;
      e.en = 1'b0;
      e.rst = 1'b0;
    end
    last_e = e;
    q.push_back(e);
  endtask
  initial begin
    exp_t e;
    int en_cnt, ln_cnt;
    bit seen_fs, seen_ls;
    en_cnt = 0;
    ln_cnt = 0;
    seen_fs = 0;
    seen_ls = 0;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        chk({s_x, s_y, h_sync, v_sync, de, ls, fs} === {e.x, e.y, e.hs, e.vs, e.de, e.ls, e.fs}, "outputs",
            $sformatf("got x=%0d y=%0d hs=%b vs=%b de=%b ls=%b fs=%b, want x=%0d y=%0d hs=%b vs=%b de=%b ls=%b fs=%b",
                      s_x, s_y, h_sync, v_sync, de, ls, fs, e.x, e.y, e.hs, e.vs, e.de, e.ls, e.fs));
        chk({p_x, p_y, p_hs, p_vs} === {e.x, e.y, ~e.hs, ~e.vs}, "pos_polarity",
            $sformatf("got x=%0d y=%0d hs=%b vs=%b, want x=%0d y=%0d hs=%b vs=%b",
                      p_x, p_y, p_hs, p_vs, e.x, e.y, ~e.hs, ~e.vs));
`ifdef DISPLAY_TIMING_FRAME_COUNT_EN
        chk(fc === e.fc, "frame_count", $sformatf("got %0d, want %0d", fc, e.fc));
`endif
        if (e.rst) begin
          en_cnt = 0;
          ln_cnt = 0;
          seen_fs = 0;
          seen_ls = 0;
        end else if (e.en) begin
          en_cnt++;
          ln_cnt++;
          if (fs === 1'b1) begin
            if (seen_fs) chk(en_cnt == 112, "frame_period", $sformatf("got %0d enabled cycles, want 112", en_cnt));
            seen_fs = 1;
            en_cnt = 0;
          end
          if (ls === 1'b1) begin
            if (seen_ls) chk(ln_cnt == 14, "line_period", $sformatf("got %0d enabled cycles, want 14", ln_cnt));
            seen_ls = 1;
            ln_cnt = 0;
          end
        end
      end
    end
  end
  initial begin
    repeat (3) step(1'b1, 1'b0);
    repeat (240) step(1'b0, 1'b1);
    for (int i = 0; i < 480; i++) step(1'b0, i % 4 == 0 || i % 4 == 3);
    while (!(mx == 5 && my == 2)) step(1'b0, 1'b1);
    repeat (3) step(1'b1, 1'b1);
    repeat (130) step(1'b0, 1'b1);
    repeat (300) step(1'b0, 1'($urandom_range(0, 1)));
    repeat (2) step(1'b1, 1'b0);
    repeat (20) step(1'b0, 1'b1);
    for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) chk(1'b0, "drain", $sformatf("got %0d pending, want 0", q.size()));
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
